// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Purpose  : Shared FSM state type and default operand width for serial_sub
//  Revision : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

   // Default operand/result width in bits
   localparam int DEFAULT_WIDTH = 8;

   // Controller states: wait for start, shift one bit per clock, present result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_fullsub_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fullsub_cell
//  Purpose  : One-bit full subtractor (a - b - bin), built from two
//             half-subtractor stages whose borrows are ORed together
//  Revision : 1.0  initial release
// ============================================================================
module fullsub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   // First half subtractor a - b, second half subtractor (a - b) - bin
   always_comb begin
      w_d1 = a ^ b;
      w_b1 = ~a & b;
      diff = w_d1 ^ bin;
      w_b2 = ~w_d1 & bin;
      bout = w_b1 | w_b2;
   end

endmodule : fullsub_cell
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub
//  Purpose  : Bit-serial subtractor, LSB first, one result bit per clock.
//             Result is (a - b) mod 2^WIDTH with the final borrow-out.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borr
);

   // Counter just wide enough to hold WIDTH, so it never wraps mid-operation
   localparam int                 c_CNT_W = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_busy;
   logic               r_done;

   logic               w_bit;
   logic               w_bout;

   // Single subtractor cell fed by the operand LSBs and the stored borrow
   fullsub_cell u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow),
      .diff (w_bit),
      .bout (w_bout)
   );

   // Controller, operand/result shift registers, borrow and bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Result registers keep the previous answer until a new start
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               // Result fills from the MSB side so the first bit ends at bit 0
               r_diff   <= {w_bit, r_diff[WIDTH-1:1]};
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + c_ONE;
               if (r_cnt == c_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               // One-cycle result strobe; start is ignored here
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign borr = r_borrow;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub
//  Purpose  : Scoreboard bench for serial_sub at WIDTH=8 and WIDTH=4
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub;

   typedef struct {
      logic [31:0] d;
      logic        br;
      int          due;
   } exp_t;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;

   logic       rst8 = 1'b1, start8 = 1'b0, busy8, done8, borr8;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic       rst4 = 1'b1, start4 = 1'b0, busy4, done4, borr4;
   logic [3:0] a4 = '0, b4 = '0, diff4;

   exp_t q8[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   // Edge index: after edge n (sampled later in that cycle) cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borr(borr8)
   );

   serial_sub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borr(borr4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain modular subtraction and unsigned compare
   function automatic exp_t model(input int w, input int av, input int bv, input int due);
      exp_t r;
      int   mask;
      mask  = (1 << w) - 1;
      r.d   = 32'((av - bv) & mask);
      r.br  = (av < bv);
      r.due = due;
      return r;
   endfunction

   // Present operands, take the accept edge, then let WIDTH+1 edges pass
   // while scrambling a/b; leaving start high makes the next call back-to-back.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit hold);
      start8 = 1'b1; a8 = av; b8 = bv;
      @(posedge clk); #1;
      q8.push_back(model(8, int'(av), int'(bv), cyc + 8));
      if (!hold) start8 = 1'b0;
      repeat (9) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv, input bit hold);
      start4 = 1'b1; a4 = av; b4 = bv;
      @(posedge clk); #1;
      q4.push_back(model(4, int'(av), int'(bv), cyc + 4));
      if (!hold) start4 = 1'b0;
      repeat (5) begin
         a4 = 4'($urandom); b4 = 4'($urandom);
         @(posedge clk); #1;
      end
   endtask

   // Monitor for the 8-bit instance
   always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (!rst8) begin
         eb = (q8.size() > 0) && (cyc >= q8[0].due - 8) && (cyc < q8[0].due);
         check("busy8", 32'(busy8), 32'(eb));
         if (done8) begin
            if (q8.size() == 0) begin
               check("unexpected_done8", 32'(done8), 32'd0);
            end else begin
               e = q8.pop_front();
               check("latency8", 32'(cyc), 32'(e.due));
               check("diff8", 32'(diff8), e.d);
               check("borr8", 32'(borr8), 32'(e.br));
            end
         end else if (q8.size() > 0 && cyc == q8[0].due) begin
            check("missing_done8", 32'(done8), 32'd1);
            void'(q8.pop_front());
         end
      end
   end

   // Monitor for the 4-bit instance
   always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (!rst4) begin
         eb = (q4.size() > 0) && (cyc >= q4[0].due - 4) && (cyc < q4[0].due);
         check("busy4", 32'(busy4), 32'(eb));
         if (done4) begin
            if (q4.size() == 0) begin
               check("unexpected_done4", 32'(done4), 32'd0);
            end else begin
               e = q4.pop_front();
               check("latency4", 32'(cyc), 32'(e.due));
               check("diff4", 32'(diff4), e.d);
               check("borr4", 32'(borr4), 32'(e.br));
            end
         end else if (q4.size() > 0 && cyc == q4[0].due) begin
            check("missing_done4", 32'(done4), 32'd1);
            void'(q4.pop_front());
         end
      end
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0; rst4 = 1'b0;
      check("reset_diff8", 32'(diff8), 32'd0);
      check("reset_borr8", 32'(borr8), 32'd0);
      check("reset_busy8", 32'(busy8), 32'd0);
      check("reset_done8", 32'(done8), 32'd0);
      check("reset_diff4", 32'(diff4), 32'd0);
      check("reset_done4", 32'(done4), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Directed corner cases
      op8(8'h05, 8'h03, 1'b0);
      op8(8'h00, 8'h01, 1'b0);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'h00, 8'hFF, 1'b0);
      op8(8'hFF, 8'h00, 1'b0);

      // start held high with operands scrambled during SHIFT
      for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), i != 5);

      // Random single-shot operations with random idle gaps
      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      // Abort during the 4th SHIFT cycle: no done, outputs cleared
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
      @(posedge clk); #1;
      q8.push_back(model(8, 32'h5A, 32'h3C, cyc + 8));
      start8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst8 = 1'b1;
      @(posedge clk); #1;
      q8.delete();
      rst8 = 1'b0;
      check("abort_diff8", 32'(diff8), 32'd0);
      check("abort_borr8", 32'(borr8), 32'd0);
      check("abort_busy8", 32'(busy8), 32'd0);
      check("abort_done8", 32'(done8), 32'd0);
      repeat (12) begin @(posedge clk); #1; end
      op8(8'h10, 8'h20, 1'b0);

      // Exhaustive 4-bit sweep, start held high throughout
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            op4(4'(x), 4'(y), !(x == 15 && y == 15));

      // Drain with a bounded wait
      t = 0;
      while ((q8.size() > 0 || q4.size() > 0) && t < 100) begin
         @(posedge clk); t++;
      end
      check("drain_q8", 32'(q8.size()), 32'd0);
      check("drain_q4", 32'(q4.size()), 32'd0);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_sub
`default_nettype wire

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port clk SHALL be: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port start SHALL be: start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 Port a SHALL be: a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 Port b SHALL be: b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 Port busy SHALL be: busy  output  1  high while a subtraction is in progress (SHIFT state).
REQ-008 Port done SHALL be: done  output  1  single-cycle pulse marking a valid result.
REQ-009 Port diff SHALL be: diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
REQ-010 Port borr SHALL be: borr  output  1  registered final borrow-out; 1 iff a < b unsigned.

Function
REQ-011 The block SHALL compute a - b bit-serially, LSB first, one bit per clk cycle, through one full-subtractor cell and a 1-bit borrow register.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at an edge SHALL: load a and b into shift registers, clear the borrow register, clear the bit counter, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL remain in IDLE with all registers holding.
REQ-015 Each SHIFT edge SHALL: compute bit = a0 ^ b0 ^ bin, bout = (~a0 & b0) | (~(a0 ^ b0) & bin); shift the bit into the result MSB side; shift operands right; store bout; increment the counter.
REQ-016 After the WIDTH-th SHIFT edge the FSM SHALL go to DONE, with diff holding the full result and borr holding the last bout.
REQ-017 DONE SHALL last exactly one cycle, then go unconditionally to IDLE.
REQ-018 done SHALL be 1 only in DONE; busy SHALL be 1 only in SHIFT; both SHALL be 0 in IDLE.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high during the cycle following edge k+WIDTH.
REQ-020 start in SHIFT or DONE SHALL be ignored (no restart, no queueing); changes on a/b after acceptance SHALL not affect the result.
REQ-021 start high in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput: one result every WIDTH+2 cycles).
REQ-022 diff and borr SHALL hold their last valid value from DONE until the next accepted start; during SHIFT they SHALL show the partial shift contents and are valid only while done=1.
REQ-023 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap within one operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borr=0, clear operand, borrow and counter registers.
REQ-025 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-026 After rst deasserts, the first start in IDLE SHALL be accepted normally.

Structure
REQ-027 A shared package serial_sub_pkg SHALL hold the state typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 The per-bit arithmetic SHALL be one combinational sub-module fullsub_cell (ports a, b, bin, diff, bout), built from two half-subtractor stages and an OR of their borrows.
REQ-029 All sequential logic (FSM, shift registers, borrow and counter registers) SHALL reside in serial_sub; the implementation SHALL fit in 120-400 lines.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x03, start 1 cycle -> done after 9 edges, diff=0x02, borr=0.
REQ-031 WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, borr=1; a=0xFF, b=0xFF -> diff=0x00, borr=0.
REQ-032 start held high throughout, with a/b changed mid-SHIFT -> exactly one done per WIDTH+2 cycles, each result matching the operands captured at acceptance.
REQ-033 rst pulsed on the 4th SHIFT cycle -> no done pulse, diff=0, borr=0, busy=0; next start a=0x10, b=0x20 -> diff=0xF0, borr=1.
REQ-034 WIDTH=4, all 256 (a,b) pairs -> diff=(a-b) mod 16, borr=(a<b), compared against a scoreboard.
